// File: rtl/register_bank_datapath_pkg.sv
// Shared constants for the register bank datapath.
// Holds the data width, register count, register address width and the
// bit positions of the overflow, carry, negative and zero flags inside Status.
package datapath_pkg;

   localparam int WIDTH      = 16;
   localparam int NREGS      = 8;
   localparam int REG_ADDR_W = $clog2(NREGS);

   // Status is laid out as {V, C, N, Z}
   localparam int FLAG_V = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

endpackage

// File: rtl/register_bank_datapath_if.sv
// Bus bundle between the control/function unit side and the register bank.
// master: drives register selects, write controls, immediate, function result,
//         memory read data and flag inputs; receives BusA/BusB, AddressOut,
//         DataOut and Status.
// slave:  the register bank datapath itself (the opposite directions).
interface register_bank_datapath_if;
   import datapath_pkg::*;

   logic [REG_ADDR_W-1:0] AA;
   logic [REG_ADDR_W-1:0] BA;
   logic [REG_ADDR_W-1:0] DA;
   logic                  RW;
   logic                  MB;
   logic                  MD;
   logic [WIDTH-1:0]      ConstantIn;
   logic [WIDTH-1:0]      FunctionResult;
   logic [WIDTH-1:0]      DataIn;
   logic                  FlagLoad;
   logic                  V_in;
   logic                  C_in;
   logic                  N_in;
   logic                  Z_in;
   logic [WIDTH-1:0]      BusA;
   logic [WIDTH-1:0]      BusB;
   logic [WIDTH-1:0]      AddressOut;
   logic [WIDTH-1:0]      DataOut;
   logic [3:0]            Status;

   modport master (
      output AA, BA, DA, RW, MB, MD, ConstantIn, FunctionResult, DataIn,
             FlagLoad, V_in, C_in, N_in, Z_in,
      input  BusA, BusB, AddressOut, DataOut, Status
   );

   modport slave (
      input  AA, BA, DA, RW, MB, MD, ConstantIn, FunctionResult, DataIn,
             FlagLoad, V_in, C_in, N_in, Z_in,
      output BusA, BusB, AddressOut, DataOut, Status
   );

endinterface

// File: rtl/register_bank_datapath_register_file.sv
// General-purpose register array: two combinational read ports and one
// synchronous write port.
// Ports: clk, reset (synchronous, active high, clears every register),
//        a_addr/a_data and b_addr/b_data (read ports),
//        we/w_addr/w_data (write port, takes effect on the rising edge).
// Reads come straight from the flops, so a write only becomes visible after
// its edge; this keeps the A-bus -> ALU -> write-data path free of a loop.
module register_file #(
   parameter int WIDTH  = datapath_pkg::WIDTH,
   parameter int NREGS  = datapath_pkg::NREGS,
   parameter int ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [WIDTH-1:0]  a_data,
   output logic [WIDTH-1:0]  b_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [WIDTH-1:0]  w_data
);
   import datapath_pkg::*;

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];

   // Write decode: only the addressed register takes the new value.
   // Register 0 is an ordinary register, not a hard-wired zero.
   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[w_addr] = w_data;
      end
   end

   // Reset overrides any write issued in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign a_data = regs_q[a_addr];
   assign b_data = regs_q[b_addr];

endmodule

// File: rtl/register_bank_datapath.sv
// Register bank datapath: register file, operand-B and write-data muxes,
// and the captured status flags.
// Ports: clk, reset (synchronous, active high), and bus (slave side of
//        register_bank_datapath_if) carrying the register selects, write
//        controls, immediate, function result, memory data, flag inputs,
//        operand buses, memory address/write data and the Status flags.
module register_bank_datapath #(
   parameter int WIDTH = datapath_pkg::WIDTH,
   parameter int NREGS = datapath_pkg::NREGS
) (
   input  logic                    clk,
   input  logic                    reset,
   register_bank_datapath_if.slave bus
);
   import datapath_pkg::*;

   logic [WIDTH-1:0] a_data;
   logic [WIDTH-1:0] b_data;
   logic [WIDTH-1:0] b_mux;
   logic [WIDTH-1:0] d_bus;
   logic [3:0]       status_d;
   logic [3:0]       status_q;

   register_file #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_register_file (
      .clk    (clk),
      .reset  (reset),
      .a_addr (bus.AA),
      .b_addr (bus.BA),
      .a_data (a_data),
      .b_data (b_data),
      .we     (bus.RW),
      .w_addr (bus.DA),
      .w_data (d_bus)
   );

   // Write data comes either from memory or from the function unit
   assign d_bus = bus.MD ? bus.DataIn : bus.FunctionResult;

   // Operand B is either a register or the immediate
   assign b_mux = bus.MB ? bus.ConstantIn : b_data;

   // Flags are captured only when asked; otherwise the previous set holds
   always_comb begin
      status_d = status_q;
      if (bus.FlagLoad) begin
         status_d[FLAG_V] = bus.V_in;
         status_d[FLAG_C] = bus.C_in;
         status_d[FLAG_N] = bus.N_in;
         status_d[FLAG_Z] = bus.Z_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         status_q <= '0;
      end else begin
         status_q <= status_d;
      end
   end

   assign bus.BusA       = a_data;
   assign bus.AddressOut = a_data;
   assign bus.BusB       = b_mux;
   assign bus.DataOut    = b_mux;
   assign bus.Status     = status_q;

endmodule

// File: tb/tb_register_bank_datapath.sv
// Self-checking bench for register_bank_datapath: directed scenarios followed
// by randomized traffic, compared against an array-based reference model.
module tb_register_bank_datapath;

   logic clk;
   logic reset;

   register_bank_datapath_if dutIf ();

   register_bank_datapath dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dutIf)
   );

   // Reference model: the registers and flags as plain variables
   logic [15:0] modelRegs [8];
   logic [3:0]  modelStatus;

   int checkCount;
   int passCount;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   // Set every control/data input of the bank at once
   task automatic applyStimulus(
      input logic [2:0]  aa, input logic [2:0] ba, input logic [2:0] da,
      input logic        rw, input logic mb, input logic md,
      input logic [15:0] constIn, input logic [15:0] funcRes, input logic [15:0] dataIn,
      input logic        flagLoad, input logic [3:0] flags
   );
      dutIf.AA             = aa;
      dutIf.BA             = ba;
      dutIf.DA             = da;
      dutIf.RW             = rw;
      dutIf.MB             = mb;
      dutIf.MD             = md;
      dutIf.ConstantIn     = constIn;
      dutIf.FunctionResult = funcRes;
      dutIf.DataIn         = dataIn;
      dutIf.FlagLoad       = flagLoad;
      dutIf.V_in           = flags[3];
      dutIf.C_in           = flags[2];
      dutIf.N_in           = flags[1];
      dutIf.Z_in           = flags[0];
      #1;
   endtask

   // One rising edge; the model applies the same rules to the held inputs
   task automatic clockEdge();
      logic [15:0] nextRegs [8];
      logic [3:0]  nextStatus;
      nextRegs   = modelRegs;
      nextStatus = modelStatus;
      if (reset) begin
         for (int i = 0; i < 8; i++) nextRegs[i] = 16'h0000;
         nextStatus = 4'b0000;
      end else begin
         if (dutIf.RW) nextRegs[dutIf.DA] = dutIf.MD ? dutIf.DataIn : dutIf.FunctionResult;
         if (dutIf.FlagLoad) nextStatus = {dutIf.V_in, dutIf.C_in, dutIf.N_in, dutIf.Z_in};
      end
      @(posedge clk);
      #1;
      modelRegs   = nextRegs;
      modelStatus = nextStatus;
   endtask

   // Read every register through BusA and compare with the model
   task automatic checkAllRegs(input string tag);
      logic [2:0] savedAa;
      savedAa = dutIf.AA;
      for (int i = 0; i < 8; i++) begin
         dutIf.AA = 3'(i);
         #1;
         checkOutput($sformatf("%s_R%0d", tag, i), dutIf.BusA, modelRegs[i]);
      end
      dutIf.AA = savedAa;
      #1;
   endtask

   // Compare all outputs against the model for the current inputs
   task automatic checkOutputsModel(input string tag);
      logic [15:0] expB;
      expB = dutIf.MB ? dutIf.ConstantIn : modelRegs[dutIf.BA];
      checkOutput({tag, "_BusA"}, dutIf.BusA, modelRegs[dutIf.AA]);
      checkOutput({tag, "_Addr"}, dutIf.AddressOut, modelRegs[dutIf.AA]);
      checkOutput({tag, "_BusB"}, dutIf.BusB, expB);
      checkOutput({tag, "_DOut"}, dutIf.DataOut, expB);
      checkOutput({tag, "_Stat"}, {12'h000, dutIf.Status}, {12'h000, modelStatus});
   endtask

   initial begin
      checkCount  = 0;
      passCount   = 0;
      modelStatus = 4'hx;
      for (int i = 0; i < 8; i++) modelRegs[i] = 16'hxxxx;

      // Reset, then read registers 3 and 5
      reset = 1'b1;
      applyStimulus(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0);
      clockEdge();
      reset = 1'b0;
      applyStimulus(3'd3, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0);
      checkOutput("rst_BusA", dutIf.BusA, 16'h0000);
      checkOutput("rst_BusB", dutIf.BusB, 16'h0000);
      checkOutput("rst_Status", {12'h000, dutIf.Status}, 16'h0000);
      applyStimulus(3'd3, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0, 16'h5A5A, 16'h0, 16'h0, 1'b0, 4'h0);
      checkOutput("rst_BusB_const", dutIf.BusB, 16'h5A5A);
      checkOutput("rst_Addr", dutIf.AddressOut, 16'h0000);

      // Memory-data write into R2
      applyStimulus(3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 16'h0, 16'hDEAD, 16'h1234, 1'b0, 4'h0);
      clockEdge();
      applyStimulus(3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0);
      checkOutput("wr_R2", dutIf.BusA, 16'h1234);
      checkAllRegs("wr");

      // Preload R4, then read and write R4 in the same cycle
      applyStimulus(3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0011, 1'b0, 4'h0);
      clockEdge();
      applyStimulus(3'd4, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 16'h0, 16'h00FF, 16'hBEEF, 1'b0, 4'h0);
      checkOutput("rw_same_before", dutIf.BusA, 16'h0011);
      clockEdge();
      dutIf.RW = 1'b0;
      #1;
      checkOutput("rw_same_after", dutIf.BusA, 16'h00FF);

      // Operand-B select between the immediate and R1
      applyStimulus(3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 16'h7777, 1'b0, 4'h0);
      clockEdge();
      applyStimulus(3'd0, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 16'h8000, 16'h0, 16'h0, 1'b0, 4'h0);
      checkOutput("mb1_BusB", dutIf.BusB, 16'h8000);
      checkOutput("mb1_DataOut", dutIf.DataOut, 16'h8000);
      dutIf.MB = 1'b0;
      #1;
      checkOutput("mb0_BusB", dutIf.BusB, 16'h7777);
      checkOutput("mb0_DataOut", dutIf.DataOut, 16'h7777);

      // Flag capture, then hold
      applyStimulus(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 4'b1010);
      clockEdge();
      checkOutput("flag_load", {12'h000, dutIf.Status}, 16'h000A);
      applyStimulus(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'b0101);
      clockEdge();
      checkOutput("flag_hold", {12'h000, dutIf.Status}, 16'h000A);

      // Reset wins over a concurrent write and flag load
      reset = 1'b1;
      applyStimulus(3'd6, 3'd0, 3'd6, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 16'hABCD, 1'b1, 4'b1111);
      clockEdge();
      reset = 1'b0;
      applyStimulus(3'd6, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0);
      checkOutput("rst_wr_R6", dutIf.BusA, 16'h0000);
      checkOutput("rst_wr_Status", {12'h000, dutIf.Status}, 16'h0000);
      checkAllRegs("rst_wr");

      // Randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         reset = ($urandom_range(0, 31) == 0);
         applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       16'($urandom), 16'($urandom), 16'($urandom),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         checkOutputsModel($sformatf("rnd%0d", n));
         clockEdge();
      end
      reset = 1'b0;
      dutIf.RW = 1'b0;
      #1;
      checkAllRegs("final");

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
